// File: rtl/mpa_mips_wb_ctrl.sv
// mpa_mips_wb_ctrl
// Writeback controller that owns the single write port of the 32x32 register
// file. Load returns always take the port; ALU results go direct when nothing
// is queued, otherwise they wait in an in-order FIFO so ALU writes retire in
// acceptance order. A per-register busy scoreboard tracks outstanding loads
// so issue logic can stall on load-use hazards.
//
// Ports
//   CLK, HW_RSTn                 clock, async active-low reset
//   ALU_VLD/ALU_RD/ALU_DATA      ALU writeback request
//   ALU_RDY                      ALU request accepted when VLD && RDY (!full)
//   LD_VLD/LD_RD/LD_DATA         load return, never backpressured
//   LD_ISSUE/LD_ISSUE_RD         load issued to memory (sets busy)
//   CHK_A0/CHK_A1                scoreboard query addresses
//   CHK_BUSY0/CHK_BUSY1          busy[CHK_Ax], register 0 never busy
//   RF_A2/RF_DIN/RF_WE           registered register-file write port
//   Q_CNT                        FIFO occupancy
module mpa_mips_wb_ctrl #(
  parameter int DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     HW_RSTn,
  input  logic                     ALU_VLD,
  input  logic [4:0]               ALU_RD,
  input  logic [31:0]              ALU_DATA,
  output logic                     ALU_RDY,
  input  logic                     LD_VLD,
  input  logic [4:0]               LD_RD,
  input  logic [31:0]              LD_DATA,
  input  logic                     LD_ISSUE,
  input  logic [4:0]               LD_ISSUE_RD,
  input  logic [4:0]               CHK_A0,
  input  logic [4:0]               CHK_A1,
  output logic                     CHK_BUSY0,
  output logic                     CHK_BUSY1,
  output logic [4:0]               RF_A2,
  output logic [31:0]              RF_DIN,
  output logic                     RF_WE,
  output logic [$clog2(DEPTH):0]   Q_CNT
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [AW:0]   r_cnt;
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [4:0]    r_mem_rd   [DEPTH];
  logic [31:0]   r_mem_data [DEPTH];
  logic [31:1]   r_busy;
  logic [4:0]    r_a2;
  logic [31:0]   r_din;
  logic          r_we;

  logic          w_alu_acc;
  logic          w_alu_nz;
  logic          w_ld_win;
  logic          w_empty;
  logic          w_pop;
  logic          w_direct;
  logic          w_push;
  logic [31:1]   w_busy_nxt;
  logic [31:0]   w_busy_all;

  assign ALU_RDY   = (r_cnt != FULL_CNT);
  assign w_empty   = (r_cnt == '0);
  assign w_alu_acc = ALU_VLD && ALU_RDY;
  // Destination-0 requests are accepted but dropped entirely.
  assign w_alu_nz  = w_alu_acc && (ALU_RD != 5'd0);
  assign w_ld_win  = LD_VLD && (LD_RD != 5'd0);
  assign w_pop     = !w_ld_win && !w_empty;
  // Direct path only with an empty FIFO keeps ALU writes in order.
  assign w_direct  = !w_ld_win && w_empty && w_alu_nz;
  assign w_push    = w_alu_nz && !w_direct;

  always_ff @(posedge CLK or negedge HW_RSTn) begin
    if (!HW_RSTn) begin
      r_cnt <= '0;
      r_wp  <= '0;
      r_rp  <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      if (w_push && !w_pop)      r_cnt <= r_cnt + 1'b1;
      else if (w_pop && !w_push) r_cnt <= r_cnt - 1'b1;
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_mem_rd[r_wp]   <= ALU_RD;
      r_mem_data[r_wp] <= ALU_DATA;
    end
  end

  always_ff @(posedge CLK or negedge HW_RSTn) begin
    if (!HW_RSTn) begin
      r_a2  <= '0;
      r_din <= '0;
      r_we  <= 1'b0;
    end else if (w_ld_win) begin
      r_a2  <= LD_RD;
      r_din <= LD_DATA;
      r_we  <= 1'b1;
    end else if (w_pop) begin
      r_a2  <= r_mem_rd[r_rp];
      r_din <= r_mem_data[r_rp];
      r_we  <= 1'b1;
    end else if (w_direct) begin
      r_a2  <= ALU_RD;
      r_din <= ALU_DATA;
      r_we  <= 1'b1;
    end else begin
      r_we  <= 1'b0;
    end
  end

  // Set is applied after clear so a re-issued load keeps the register busy.
  always_comb begin
    w_busy_nxt = r_busy;
    if (LD_VLD && (LD_RD != 5'd0))
      w_busy_nxt[LD_RD] = 1'b0;
    if (LD_ISSUE && (LD_ISSUE_RD != 5'd0))
      w_busy_nxt[LD_ISSUE_RD] = 1'b1;
  end

  always_ff @(posedge CLK or negedge HW_RSTn) begin
    if (!HW_RSTn) r_busy <= '0;
    else          r_busy <= w_busy_nxt;
  end

  assign w_busy_all = {r_busy, 1'b0};
  assign CHK_BUSY0  = w_busy_all[CHK_A0];
  assign CHK_BUSY1  = w_busy_all[CHK_A1];

  assign RF_A2  = r_a2;
  assign RF_DIN = r_din;
  assign RF_WE  = r_we;
  assign Q_CNT  = r_cnt;

endmodule

// File: tb/tb_mpa_mips_wb_ctrl.sv
module tb_mpa_mips_wb_ctrl;

  logic        CLK = 1'b0;
  logic        HW_RSTn;
  logic        ALU_VLD;
  logic [4:0]  ALU_RD;
  logic [31:0] ALU_DATA;
  logic        ALU_RDY;
  logic        LD_VLD;
  logic [4:0]  LD_RD;
  logic [31:0] LD_DATA;
  logic        LD_ISSUE;
  logic [4:0]  LD_ISSUE_RD;
  logic [4:0]  CHK_A0;
  logic [4:0]  CHK_A1;
  logic        CHK_BUSY0;
  logic        CHK_BUSY1;
  logic [4:0]  RF_A2;
  logic [31:0] RF_DIN;
  logic        RF_WE;
  logic [2:0]  Q_CNT;

  always #5 CLK = ~CLK;

  mpa_mips_wb_ctrl #(.DEPTH(4)) dut (
    .CLK(CLK), .HW_RSTn(HW_RSTn),
    .ALU_VLD(ALU_VLD), .ALU_RD(ALU_RD), .ALU_DATA(ALU_DATA), .ALU_RDY(ALU_RDY),
    .LD_VLD(LD_VLD), .LD_RD(LD_RD), .LD_DATA(LD_DATA),
    .LD_ISSUE(LD_ISSUE), .LD_ISSUE_RD(LD_ISSUE_RD),
    .CHK_A0(CHK_A0), .CHK_A1(CHK_A1), .CHK_BUSY0(CHK_BUSY0), .CHK_BUSY1(CHK_BUSY1),
    .RF_A2(RF_A2), .RF_DIN(RF_DIN), .RF_WE(RF_WE), .Q_CNT(Q_CNT)
  );

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t exp_q[$];
  int  total = 0;
  int  bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every register-file write must match the next expected write.
  always @(negedge CLK) begin
    if (HW_RSTn === 1'b1 && RF_WE !== 1'b0) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write actual a2=%0d din=%0h required none", RF_A2, RF_DIN);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wb_addr", 32'(RF_A2), 32'(e.a));
        chk("wb_data", RF_DIN, e.d);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    ALU_VLD = 1'b0; ALU_RD = '0; ALU_DATA = '0;
    LD_VLD = 1'b0; LD_RD = '0; LD_DATA = '0;
    LD_ISSUE = 1'b0; LD_ISSUE_RD = '0;
  endtask

  // Preemption scenario tables: ALU_RDY seen before each cycle, Q_CNT after.
  logic [6:0] exp_rdy_bits;
  int         exp_cnt_tab [10] = '{1, 2, 3, 4, 4, 3, 3, 2, 1, 0};

  initial begin
    int k;
    logic rdy_seen;
    exp_rdy_bits = 7'b1001111; // bit c = expected ALU_RDY in cycle c
    idle_inputs();
    CHK_A0 = '0; CHK_A1 = '0;
    HW_RSTn = 1'b0;
    tick(); tick();

    // Reset values
    chk("rst_we",    32'(RF_WE), 0);
    chk("rst_a2",    32'(RF_A2), 0);
    chk("rst_din",   RF_DIN, 0);
    chk("rst_qcnt",  32'(Q_CNT), 0);
    chk("rst_rdy",   32'(ALU_RDY), 1);
    chk("rst_busy0", 32'(CHK_BUSY0), 0);
    chk("rst_busy1", 32'(CHK_BUSY1), 0);
    HW_RSTn = 1'b1;
    tick();

    // Direct ALU path: one-cycle latency, FIFO untouched
    ALU_VLD = 1'b1; ALU_RD = 5'd5; ALU_DATA = 32'hDEADBEEF;
    exp_q.push_back('{a: 5'd5, d: 32'hDEADBEEF});
    tick();
    idle_inputs();
    chk("direct_we",   32'(RF_WE), 1);
    chk("direct_a2",   32'(RF_A2), 5);
    chk("direct_din",  RF_DIN, 32'hDEADBEEF);
    chk("direct_qcnt", 32'(Q_CNT), 0);
    tick();
    chk("direct_we_drop", 32'(RF_WE), 0);

    // Load preemption: 5 loads win the port, ALU rd 1..5 retire afterwards in order
    for (int i = 0; i < 5; i++) exp_q.push_back('{a: 5'd8, d: 32'h11});
    for (int i = 1; i <= 5; i++) exp_q.push_back('{a: 5'(i), d: 32'hA0 + 32'(i)});
    k = 1;
    for (int c = 0; c < 10; c++) begin
      LD_VLD  = (c < 5);
      LD_RD   = (c < 5) ? 5'd8 : 5'd0;
      LD_DATA = (c < 5) ? 32'h11 : 32'h0;
      ALU_VLD = (k <= 5);
      ALU_RD  = 5'(k);
      ALU_DATA = 32'hA0 + 32'(k);
      rdy_seen = ALU_RDY;
      if (c < 7) chk($sformatf("pre_rdy_c%0d", c), 32'(ALU_RDY), 32'(exp_rdy_bits[c]));
      tick();
      if (ALU_VLD && rdy_seen) k++;
      chk($sformatf("pre_qcnt_c%0d", c), 32'(Q_CNT), 32'(exp_cnt_tab[c]));
    end
    idle_inputs();
    tick();
    chk("pre_drained", 32'(exp_q.size()), 0);

    // Zero register: nothing written, nothing queued, never busy
    ALU_VLD = 1'b1; ALU_RD = 5'd0; ALU_DATA = 32'h1234;
    LD_VLD = 1'b1; LD_RD = 5'd0; LD_DATA = 32'h5678;
    LD_ISSUE = 1'b1; LD_ISSUE_RD = 5'd0;
    CHK_A0 = 5'd0;
    tick();
    idle_inputs();
    chk("zero_we",    32'(RF_WE), 0);
    chk("zero_qcnt",  32'(Q_CNT), 0);
    chk("zero_busy0", 32'(CHK_BUSY0), 0);
    tick();

    // Scoreboard: set, same-cycle set+clear keeps busy, lone clear releases
    CHK_A0 = 5'd9; CHK_A1 = 5'd10;
    LD_ISSUE = 1'b1; LD_ISSUE_RD = 5'd9;
    chk("sb_pre_busy", 32'(CHK_BUSY0), 0);
    tick();
    idle_inputs();
    chk("sb_set_busy",   32'(CHK_BUSY0), 1);
    chk("sb_other_free", 32'(CHK_BUSY1), 0);
    tick(); tick();
    LD_VLD = 1'b1; LD_RD = 5'd9; LD_DATA = 32'h99;
    LD_ISSUE = 1'b1; LD_ISSUE_RD = 5'd9;
    exp_q.push_back('{a: 5'd9, d: 32'h99});
    tick();
    idle_inputs();
    chk("sb_setwins_busy", 32'(CHK_BUSY0), 1);
    tick();
    LD_VLD = 1'b1; LD_RD = 5'd9; LD_DATA = 32'h77;
    exp_q.push_back('{a: 5'd9, d: 32'h77});
    chk("sb_still_busy", 32'(CHK_BUSY0), 1);
    tick();
    idle_inputs();
    chk("sb_clear_busy", 32'(CHK_BUSY0), 0);
    tick();

    // Mid-operation reset with 3 queued ALU entries. The third load write is
    // registered but reset lands before the monitor's negedge sample, so only
    // two load writes are expected; the queued ALU writes must never appear.
    exp_q.push_back('{a: 5'd12, d: 32'h5});
    exp_q.push_back('{a: 5'd12, d: 32'h5});
    for (int c = 0; c < 3; c++) begin
      LD_VLD = 1'b1; LD_RD = 5'd12; LD_DATA = 32'h5;
      ALU_VLD = 1'b1; ALU_RD = 5'(20 + c); ALU_DATA = 32'hC0 + 32'(c);
      LD_ISSUE = 1'b1; LD_ISSUE_RD = 5'(20 + c);
      tick();
    end
    idle_inputs();
    chk("mid_qcnt_before", 32'(Q_CNT), 3);
    #1;
    HW_RSTn = 1'b0;
    #1;
    chk("mid_rst_we",   32'(RF_WE), 0);
    chk("mid_rst_qcnt", 32'(Q_CNT), 0);
    chk("mid_rst_rdy",  32'(ALU_RDY), 1);
    CHK_A0 = 5'd20; CHK_A1 = 5'd22;
    #1;
    chk("mid_rst_busy0", 32'(CHK_BUSY0), 0);
    chk("mid_rst_busy1", 32'(CHK_BUSY1), 0);
    tick();
    HW_RSTn = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    chk("mid_post_qcnt", 32'(Q_CNT), 0);
    chk("final_drained", 32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mpa_mips_wb_ctrl.md
# mpa_mips_wb_ctrl

Writeback controller and sole initiator of the 32x32 MIPS register file's single write port. It merges ALU results and late-returning load data onto one registered write port (address, data, write enable), buffering ALU results in a small in-order FIFO when loads take the port. It also keeps a per-register busy scoreboard for outstanding loads, so the issue logic can stall on load-use hazards.

## Interface
- `DEPTH`, 4: ALU deferral FIFO entries; power of two, ≥2.
- `CLK` in 1: clock, all state on rising edge.
- `HW_RSTn` in 1: reset. One clock; reset is asynchronous and active-low.
- `ALU_VLD` in 1: ALU writeback request.
- `ALU_RD` in 5: ALU destination register.
- `ALU_DATA` in 32: ALU result.
- `ALU_RDY` out 1: ALU request accepted when `ALU_VLD && ALU_RDY`. Equals `!full`, from registered count.
- `LD_VLD` in 1: load return; always accepted, no backpressure.
- `LD_RD` in 5: load destination.
- `LD_DATA` in 32: load data.
- `LD_ISSUE` in 1: a load to `LD_ISSUE_RD` was issued to memory.
- `LD_ISSUE_RD` in 5: destination of the issued load.
- `CHK_A0`, `CHK_A1` in 5 each: scoreboard query addresses.
- `CHK_BUSY0`, `CHK_BUSY1` out 1 each: combinational `busy[CHK_Ax]`; always 0 for register 0.
- `RF_A2` out 5: register-file write address (registered).
- `RF_DIN` out 32: register-file write data (registered).
- `RF_WE` out 1: register-file write enable (registered).
- `Q_CNT` out log2(DEPTH)+1: FIFO occupancy.

## Operation
- Requests with destination 0 (ALU or load) are accepted and discarded. They never assert `RF_WE` and never enter the FIFO.
- Per-cycle write-port priority, evaluated on sampled inputs:
  1. `LD_VLD` with `LD_RD` ≠ 0.
  2. FIFO head (pop).
  3. Accepted ALU request direct, only when the FIFO is empty.
- An accepted ALU request is pushed to the FIFO whenever it does not win the port. This covers the case where a load wins, and also the case where the FIFO is non-empty.
  - ALU writes therefore retire strictly in acceptance order.
- Push and pop may occur in the same cycle; `Q_CNT` is then unchanged.
  - No push can occur when full, because `ALU_RDY` = 0.
- Winner is registered into `RF_A2`/`RF_DIN` with `RF_WE`=1 for exactly one cycle. With no winner, `RF_WE`=0 and `RF_A2`/`RF_DIN` hold their last value.
- FIFO pointers are log2(DEPTH) bits and wrap modulo DEPTH. Full = count==DEPTH; empty = count==0.
- Scoreboard `busy[31:1]`:
  - `LD_ISSUE` with rd≠0 sets `busy[LD_ISSUE_RD]`.
  - `LD_VLD` clears `busy[LD_RD]` on the same edge the write is registered.
  - Same-cycle set and clear of the same register: set wins (a new load is outstanding).
- The block does not reorder ALU writes against load writes to the same register. Issue logic must stall on `CHK_BUSYx` to prevent WAW and RAW hazards against pending loads.

## Timing
- Reset (async assert, sync-to-`CLK` deassert use) puts the block in this state:
  - `RF_WE`=0, `RF_A2`=0, `RF_DIN`=0.
  - FIFO empty: `Q_CNT`=0, `ALU_RDY`=1.
  - All busy bits 0.
- Reset mid-operation discards queued ALU writes and clears the scoreboard immediately, with no write emitted.
- Latency from request to `RF_WE`:
  - Load: 1 cycle, always.
  - ALU with FIFO empty and no load: 1 cycle.
  - Otherwise: 1 + (entries ahead) + (load cycles that preempt it).
- `ALU_RDY` updates on the cycle after the count changes. A full FIFO with a pop deasserts `ALU_RDY` for that cycle; there is no same-cycle bypass.
- `CHK_BUSYx` reflects state after the last edge. A load issued at edge N shows busy from N+1. A load returned at edge N shows not-busy from N+1.
- The register file writes on the edge after `RF_WE` is high. End-to-end from a request to updated register contents is 2 edges.

## Test plan
- Reset values: hold `HW_RSTn`=0 → `RF_WE`=0, `RF_A2`=0, `RF_DIN`=0, `Q_CNT`=0, `ALU_RDY`=1, `CHK_BUSY0`/`CHK_BUSY1`=0.
- Direct ALU path: ALU rd=5, data=0xDEADBEEF, idle otherwise → next cycle `RF_WE`=1, `RF_A2`=5, `RF_DIN`=0xDEADBEEF; `Q_CNT` stays 0.
- Load preemption: `LD_VLD` rd=8 data=0x11 for 5 consecutive cycles while ALU issues rd=1..5 (data 0xA1..0xA5) in the same cycles:
  - `ALU_RDY` drops after 4 accepts, so rd=5 waits.
  - Loads are written on cycles 1–5.
  - ALU writes then retire rd=1,2,3,4,5 in order on the following cycles.
  - `Q_CNT` peaks at 4.
- Zero register: ALU rd=0 and load rd=0 in the same cycle → `RF_WE` stays 0; `Q_CNT` unchanged; `CHK_BUSY0`=0 even after `LD_ISSUE` rd=0.
- Scoreboard: `LD_ISSUE` rd=9, then 3 cycles later `LD_VLD` rd=9 together with `LD_ISSUE` rd=9 → busy[9] stays 1. A later `LD_VLD` rd=9 alone clears it (`CHK_BUSY0` with `CHK_A0`=9 goes 0 the next cycle).
- Mid-operation reset: FIFO holding 3 entries, assert `HW_RSTn`=0 between edges → `RF_WE`=0 and `Q_CNT`=0 immediately. After release, no stale writes appear.
